sram_arbiter: RTL and testbench

- Shares the single SRAM port between NUM_REQ requesters: header parser (port 0), packet loader (port 1), config/table writer (port 2).
- Each requester runs a req/ack handshake. The arbiter picks a winner round-robin, drives the SRAM bus from registers, and waits the fixed SRAM read latency. It then returns read data with a one-cycle ack pulse.
- An optional lock lets one requester chain accesses without interleaving, e.g. a parser header walk.

---
 rtl/sram_arbiter_pkg.sv | 28 ++
 rtl/sram_arbiter_rr_pick.sv | 42 ++++
 rtl/sram_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter_pkg
//  Description : Shared encodings and constants for the SRAM port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_arbiter_pkg;

    localparam logic [1:0] AR_STATE_IDLE    = 2'd0;
    localparam logic [1:0] AR_STATE_RD_WAIT = 2'd1;
    localparam logic [1:0] AR_STATE_WR      = 2'd2;
    localparam logic [1:0] AR_STATE_ACK     = 2'd3;

    localparam int SRAM_READ_LAT = 2;

    localparam logic [2:0] REQ_PARSER = 3'd0;
    localparam logic [2:0] REQ_LOADER = 3'd1;
    localparam logic [2:0] REQ_CFG    = 3'd2;

    typedef logic [2:0] req_id_t;

    // Round-robin successor with modulo wrap over n requesters.
    function automatic req_id_t next_ptr(input req_id_t id, input int n);
        return (id == 3'(n - 1)) ? 3'd0 : id + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin first-one finder starting at ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import sram_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [2:0]         idx,
    output logic               found
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [3:0]           w_pos;
    logic [3:0]           w_sum;

    // Rotating a doubled copy right by ptr puts requester ptr at bit 0;
    // the lowest set bit is then the distance to the winner.
    always_comb begin
        w_dbl = {req, req} >> ptr;
        w_pos = 4'd0;
        found = 1'b0;
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            if (w_dbl[i]) begin
                w_pos = 4'(i);
                found = 1'b1;
            end
        end
        w_sum = {1'b0, ptr} + w_pos;
        if (w_sum >= 4'(NUM_REQ)) begin
            w_sum = w_sum - 4'(NUM_REQ);
        end
        idx = w_sum[2:0];
    end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Round-robin arbiter with optional lock sharing one SRAM port.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = SRAM_READ_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ-1:0]    req_we_i,
    input  logic [NUM_REQ-1:0]    req_lock_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*4-1:0]  req_sel_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]    ack_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [2:0]            grant_id_o,
    output logic                  busy_o,
    output logic                  sram_ce_o,
    output logic                  sram_we_o,
    output logic [ADDR_W-1:0]     sram_addr_o,
    output logic [3:0]            sram_sel_o,
    output logic [DATA_W-1:0]     sram_data_o,
    input  logic [DATA_W-1:0]     sram_data_i
);

    localparam int c_CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(READ_LAT - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    req_id_t            r_ptr;
    req_id_t            r_lock_id;
    logic               r_lock_vld;

    req_id_t            w_pick_idx;
    logic               w_pick_found;
    logic               w_lock_req;
    logic               w_grant_lock;
    logic               w_lock_hit;
    req_id_t            w_win_id;
    logic               w_win_vld;
    logic               w_win_we;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [3:0]         w_win_sel;
    logic [DATA_W-1:0]  w_win_data;
    logic [NUM_REQ-1:0] w_ack_vec;

    logic w_grant;
    logic w_cnt_dec;
    logic w_rd_done;
    logic w_wr_done;
    logic w_ack_end;
    logic w_lock_clr;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req   (req_i),
        .ptr   (r_ptr),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    // Winner selection and per-requester field muxing.
    always_comb begin
        w_lock_req   = 1'b0;
        w_grant_lock = 1'b0;
        w_ack_vec    = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (r_lock_id == 3'(j))  w_lock_req   = req_i[j];
            if (grant_id_o == 3'(j)) w_grant_lock = req_lock_i[j];
            if (grant_id_o == 3'(j)) w_ack_vec[j] = 1'b1;
        end
        w_lock_hit = r_lock_vld && w_lock_req;
        w_win_id   = w_lock_hit ? r_lock_id : w_pick_idx;
        w_win_vld  = w_lock_hit || w_pick_found;

        w_win_we   = 1'b0;
        w_win_addr = '0;
        w_win_sel  = '0;
        w_win_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_win_id == 3'(j)) begin
                w_win_we   = req_we_i[j];
                w_win_addr = req_addr_i[j*ADDR_W +: ADDR_W];
                w_win_sel  = req_sel_i[j*4 +: 4];
                w_win_data = req_wdata_i[j*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= AR_STATE_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            AR_STATE_IDLE:    if (w_win_vld) w_next_state = w_win_we ? AR_STATE_WR : AR_STATE_RD_WAIT;
            AR_STATE_RD_WAIT: if (r_cnt == '0) w_next_state = AR_STATE_ACK;
            AR_STATE_WR:      w_next_state = AR_STATE_ACK;
            AR_STATE_ACK:     w_next_state = AR_STATE_IDLE;
            default:          w_next_state = AR_STATE_IDLE;
        endcase
    end

    always_comb begin
        w_grant    = (r_state == AR_STATE_IDLE) && w_win_vld;
        w_cnt_dec  = (r_state == AR_STATE_RD_WAIT) && (r_cnt != '0);
        w_rd_done  = (r_state == AR_STATE_RD_WAIT) && (r_cnt == '0);
        w_wr_done  = (r_state == AR_STATE_WR);
        w_ack_end  = (r_state == AR_STATE_ACK);
        w_lock_clr = (r_state == AR_STATE_IDLE) && r_lock_vld && !w_lock_req;
    end

    assign busy_o = (r_state != AR_STATE_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_o       <= '0;
            rdata_o     <= '0;
            grant_id_o  <= '0;
            sram_ce_o   <= 1'b0;
            sram_we_o   <= 1'b0;
            sram_addr_o <= '0;
            sram_sel_o  <= '0;
            sram_data_o <= '0;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_lock_id   <= '0;
            r_lock_vld  <= 1'b0;
        end else begin
            if (w_grant) begin
                sram_ce_o   <= 1'b1;
                sram_we_o   <= w_win_we;
                sram_addr_o <= w_win_addr;
                sram_sel_o  <= w_win_sel;
                sram_data_o <= w_win_data;
                grant_id_o  <= w_win_id;
                r_ptr       <= next_ptr(w_win_id, NUM_REQ);
                r_cnt       <= c_CNT_LOAD;
            end
            if (w_cnt_dec) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_rd_done) begin
                rdata_o   <= sram_data_i;
                ack_o     <= w_ack_vec;
                sram_ce_o <= 1'b0;
            end
            if (w_wr_done) begin
                sram_ce_o <= 1'b0;
                sram_we_o <= 1'b0;
                ack_o     <= w_ack_vec;
            end
            // Lock is taken from the owner's lock bit as seen during ACK.
            if (w_ack_end) begin
                ack_o      <= '0;
                r_lock_vld <= w_grant_lock;
                r_lock_id  <= grant_id_o;
            end
            if (w_lock_clr) begin
                r_lock_vld <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_arbiter
//  Description : Directed self-checking bench for sram_arbiter with SRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req, we, lock;
    logic [95:0] addr;
    logic [11:0] sel;
    logic [95:0] wdata;
    logic [2:0]  ack_o;
    logic [31:0] rdata_o;
    logic [2:0]  grant_id_o;
    logic        busy_o;
    logic        sram_ce_o, sram_we_o;
    logic [31:0] sram_addr_o;
    logic [3:0]  sram_sel_o;
    logic [31:0] sram_data_o;
    logic [31:0] sram_q;

    logic [31:0] mem [0:255];
    int n_vec;
    int n_err;

    always #5 clk = ~clk;

    sram_arbiter #(
        .NUM_REQ (3), .ADDR_W (32), .DATA_W (32), .READ_LAT (2)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .req_i (req), .req_we_i (we), .req_lock_i (lock),
        .req_addr_i (addr), .req_sel_i (sel), .req_wdata_i (wdata),
        .ack_o (ack_o), .rdata_o (rdata_o), .grant_id_o (grant_id_o), .busy_o (busy_o),
        .sram_ce_o (sram_ce_o), .sram_we_o (sram_we_o), .sram_addr_o (sram_addr_o),
        .sram_sel_o (sram_sel_o), .sram_data_o (sram_data_o), .sram_data_i (sram_q)
    );

    function automatic logic [31:0] exp_word(input int i);
        if (i == 3) return 32'h0800_0001;
        return {8'hA5, 8'(i), 16'(i * 3)};
    endfunction

    // SRAM model: one registered read cycle, byte-masked writes.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= exp_word(i);
        end else if (sram_ce_o && sram_we_o) begin
            for (int b = 0; b < 4; b++)
                if (sram_sel_o[b]) mem[sram_addr_o[9:2]][b*8 +: 8] <= sram_data_o[b*8 +: 8];
        end else if (sram_ce_o) begin
            sram_q <= mem[sram_addr_o[9:2]];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic w, input logic l,
                            input logic [31:0] a, input logic [31:0] d);
        req[p]            = r;
        we[p]             = w;
        lock[p]           = l;
        addr[p*32 +: 32]  = a;
        sel[p*4 +: 4]     = 4'hF;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({sram_ce_o, sram_we_o, ack_o, busy_o, grant_id_o} !== 9'd0) begin
            n_err++; $display("FAIL reset_ctrl got %b exp 0", {sram_ce_o, sram_we_o, ack_o, busy_o, grant_id_o});
        end
        n_vec++;
        if ({rdata_o, sram_addr_o, sram_data_o, sram_sel_o} !== 100'd0) begin
            n_err++; $display("FAIL reset_data got %h/%h/%h/%h exp 0", rdata_o, sram_addr_o, sram_data_o, sram_sel_o);
        end
        rst_n = 1'b1;
        tick;
        n_vec++;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_idle busy got %b exp 0", busy_o); end
    endtask

    task automatic test_single_read;
        set_port(0, 1'b1, 1'b0, 1'b0, 32'h0C, 32'h0);
        tick;
        n_vec++;
        if ({sram_ce_o, sram_we_o, busy_o, grant_id_o} !== 6'b101_000) begin
            n_err++; $display("FAIL rd_e0_ctrl got %b exp 101000", {sram_ce_o, sram_we_o, busy_o, grant_id_o});
        end
        n_vec++;
        if (sram_addr_o !== 32'h0C) begin n_err++; $display("FAIL rd_e0_addr got %h exp 0000000c", sram_addr_o); end
        tick;
        n_vec++;
        if ({sram_ce_o, ack_o} !== 4'b1_000) begin n_err++; $display("FAIL rd_e1 ce/ack got %b exp 1000", {sram_ce_o, ack_o}); end
        tick;
        n_vec++;
        if ({sram_ce_o, ack_o} !== 4'b0_001) begin n_err++; $display("FAIL rd_e2 ce/ack got %b exp 0001", {sram_ce_o, ack_o}); end
        n_vec++;
        if (rdata_o !== 32'h0800_0001) begin n_err++; $display("FAIL rd_data got %h exp 08000001", rdata_o); end
        set_port(0, 1'b0, 1'b0, 1'b0, 32'h0C, 32'h0);
        tick;
        n_vec++;
        if ({ack_o, busy_o} !== 4'b000_0) begin n_err++; $display("FAIL rd_after ack/busy got %b exp 0000", {ack_o, busy_o}); end
    endtask

    task automatic test_single_write;
        set_port(2, 1'b1, 1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF);
        tick;
        n_vec++;
        if ({sram_ce_o, sram_we_o, grant_id_o, ack_o} !== 8'b11_010_000) begin
            n_err++; $display("FAIL wr_e0 ce/we/gnt/ack got %b exp 11010000", {sram_ce_o, sram_we_o, grant_id_o, ack_o});
        end
        n_vec++;
        if ({sram_addr_o, sram_data_o} !== {32'h40, 32'hDEAD_BEEF}) begin
            n_err++; $display("FAIL wr_e0_bus got %h/%h exp 00000040/deadbeef", sram_addr_o, sram_data_o);
        end
        tick;
        n_vec++;
        if ({sram_ce_o, sram_we_o, ack_o} !== 5'b00_100) begin
            n_err++; $display("FAIL wr_e1 ce/we/ack got %b exp 00100", {sram_ce_o, sram_we_o, ack_o});
        end
        n_vec++;
        if (mem[16] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_mem got %h exp deadbeef", mem[16]); end
        n_vec++;
        if (rdata_o !== 32'h0800_0001) begin n_err++; $display("FAIL wr_rdata_hold got %h exp 08000001", rdata_o); end
        set_port(2, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
        tick;
        n_vec++;
        if (ack_o !== 3'b000) begin n_err++; $display("FAIL wr_ack_clr got %b exp 000", ack_o); end
    endtask

    task automatic test_contention;
        logic [2:0] e_ack;
        for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b0, 1'b0, 32'(p * 4), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick;
            n_vec++;
            if (grant_id_o !== 3'(k)) begin n_err++; $display("FAIL cont_grant%0d got %0d exp %0d", k, grant_id_o, k); end
            tick;
            tick;
            e_ack = 3'b001 << k;
            n_vec++;
            if (ack_o !== e_ack) begin n_err++; $display("FAIL cont_ack%0d got %b exp %b", k, ack_o, e_ack); end
            n_vec++;
            if (rdata_o !== exp_word(k)) begin n_err++; $display("FAIL cont_data%0d got %h exp %h", k, rdata_o, exp_word(k)); end
            req[k] = 1'b0;
            tick;
        end
        req = 3'b111;
        tick;
        n_vec++;
        if (grant_id_o !== 3'd0) begin n_err++; $display("FAIL cont_round2 got %0d exp 0", grant_id_o); end
        tick;
        tick;
        n_vec++;
        if (ack_o !== 3'b001) begin n_err++; $display("FAIL cont_round2_ack got %b exp 001", ack_o); end
        req = 3'b000;
        tick;
    endtask

    task automatic test_lock;
        set_port(0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
        tick;
        set_port(1, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                tick;
                n_vec++;
                if ({grant_id_o, busy_o} !== 4'b000_1) begin
                    n_err++; $display("FAIL lock_grant%0d gnt/busy got %b exp 0001", k, {grant_id_o, busy_o});
                end
            end
            tick;
            tick;
            n_vec++;
            if (ack_o !== 3'b001 || rdata_o !== exp_word(8 + k)) begin
                n_err++; $display("FAIL lock_ack%0d got %b/%h exp 001/%h", k, ack_o, rdata_o, exp_word(8 + k));
            end
            if (k < 2) set_port(0, 1'b1, 1'b0, 1'b1, 32'(32'h24 + k * 4), 32'h0);
            else       set_port(0, 1'b0, 1'b0, 1'b1, 32'h28, 32'h0);
            tick;
        end
        tick;
        n_vec++;
        if ({grant_id_o, sram_addr_o} !== {3'd1, 32'h30}) begin
            n_err++; $display("FAIL lock_release got %0d/%h exp 1/00000030", grant_id_o, sram_addr_o);
        end
        tick;
        tick;
        n_vec++;
        if (ack_o !== 3'b010 || rdata_o !== exp_word(12)) begin
            n_err++; $display("FAIL lock_p1_ack got %b/%h exp 010/%h", ack_o, rdata_o, exp_word(12));
        end
        set_port(1, 1'b0, 1'b0, 1'b0, 32'h30, 32'h0);
        lock = 3'b000;
        tick;
    endtask

    task automatic test_async_reset;
        set_port(1, 1'b1, 1'b0, 1'b0, 32'h04, 32'h0);
        tick;
        n_vec++;
        if ({sram_ce_o, grant_id_o} !== 4'b1_001) begin n_err++; $display("FAIL ar_pre got %b exp 1001", {sram_ce_o, grant_id_o}); end
        set_port(2, 1'b1, 1'b0, 1'b0, 32'h08, 32'h0);
        tick;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({sram_ce_o, ack_o, busy_o, grant_id_o} !== 8'd0 || rdata_o !== 32'd0 || sram_addr_o !== 32'd0) begin
            n_err++; $display("FAIL ar_immediate got %b/%h/%h exp 0", {sram_ce_o, ack_o, busy_o, grant_id_o}, rdata_o, sram_addr_o);
        end
        tick;
        n_vec++;
        if ({ack_o, busy_o} !== 4'd0) begin n_err++; $display("FAIL ar_held got %b exp 0000", {ack_o, busy_o}); end
        rst_n = 1'b1;
        tick;
        n_vec++;
        if ({grant_id_o, busy_o} !== 4'b001_1) begin n_err++; $display("FAIL ar_regrant got %b exp 0011", {grant_id_o, busy_o}); end
        tick;
        tick;
        n_vec++;
        if (ack_o !== 3'b010 || rdata_o !== exp_word(1)) begin
            n_err++; $display("FAIL ar_ack1 got %b/%h exp 010/%h", ack_o, rdata_o, exp_word(1));
        end
        req[1] = 1'b0;
        tick;
        tick;
        n_vec++;
        if (grant_id_o !== 3'd2) begin n_err++; $display("FAIL ar_grant2 got %0d exp 2", grant_id_o); end
        tick;
        tick;
        n_vec++;
        if (ack_o !== 3'b100 || rdata_o !== exp_word(2)) begin
            n_err++; $display("FAIL ar_ack2 got %b/%h exp 100/%h", ack_o, rdata_o, exp_word(2));
        end
        req[2] = 1'b0;
        tick;
    endtask

    task automatic test_req_drop;
        set_port(1, 1'b1, 1'b0, 1'b0, 32'h0C, 32'h0);
        tick;
        n_vec++;
        if (grant_id_o !== 3'd1) begin n_err++; $display("FAIL drop_grant got %0d exp 1", grant_id_o); end
        req[1] = 1'b0;
        tick;
        tick;
        n_vec++;
        if (ack_o !== 3'b010 || rdata_o !== 32'h0800_0001) begin
            n_err++; $display("FAIL drop_ack got %b/%h exp 010/08000001", ack_o, rdata_o);
        end
        tick;
        n_vec++;
        if (ack_o !== 3'b000) begin n_err++; $display("FAIL drop_ack_clr got %b exp 000", ack_o); end
        for (int k = 0; k < 3; k++) begin
            tick;
            n_vec++;
            if ({busy_o, sram_ce_o, ack_o, grant_id_o} !== 8'b0_0_000_001) begin
                n_err++; $display("FAIL drop_idle%0d got %b exp 00000001", k, {busy_o, sram_ce_o, ack_o, grant_id_o});
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        lock  = '0;
        addr  = '0;
        sel   = '0;
        wdata = '0;
        test_reset;
        test_single_read;
        test_single_write;
        test_contention;
        test_lock;
        test_async_reset;
        test_req_drop;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
